// File: rtl/fdivsqrt_r4ctrl.sv
// fdivsqrt_r4ctrl: radix-4 div/sqrt iteration sequencer (IDLE/BUSY/DONE).
// Ports: req_* accept handshake, iter_en/init/first_iter drive datapath, done_* result handshake.
module fdivsqrt_r4ctrl #(
  parameter int CYCW = 6
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            sqrt_i,
  input  logic [CYCW-1:0] cycles_i,
  input  logic            special_i,
  input  logic            early_stop_i,
  input  logic            flush,
  output logic            init,
  output logic            iter_en,
  output logic            first_iter,
  output logic            sqrt_q,
  output logic            busy,
  output logic            done_valid,
  input  logic            done_ready,
  output logic            special_q,
  output logic            early_q
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } st_e;

  st_e             st_q, st_d;
  logic [CYCW-1:0] cnt_q, cnt_d;
  logic [CYCW-1:0] ld_q, ld_d;
  logic            fi_q, fi_d;
  logic            sq_d, sp_d, ea_d;
  logic            in_idle, in_busy, in_done;

  assign in_idle = (st_q == S_IDLE);
  assign in_busy = (st_q == S_BUSY);
  assign in_done = (st_q == S_DONE);

  assign req_ready  = in_idle & ~flush;
  assign init       = req_valid & req_ready;
  assign iter_en    = in_busy & ~flush;
  assign first_iter = in_busy & fi_q
                    & (cnt_q == ld_q);
  assign busy       = ~in_idle;
  assign done_valid = in_done & ~flush;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    ld_d  = ld_q;
    fi_d  = fi_q;
    sq_d  = sqrt_q;
    sp_d  = special_q;
    ea_d  = early_q;
    if (flush) begin
      st_d = S_IDLE;
      fi_d = 1'b0;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          if (init) begin
            sq_d = sqrt_i;
            sp_d = special_i;
            ea_d = 1'b0;
            fi_d = 1'b1;
            if (special_i || (cycles_i == '0)) begin
              st_d = S_DONE;
            end else begin
              st_d  = S_BUSY;
              cnt_d = cycles_i;
              ld_d  = cycles_i;
            end
          end
        end
        S_BUSY: begin
          fi_d = 1'b0;
          // Saturate at 1 so the last-cycle test stays valid.
          if (cnt_q > CYCW'(1)) begin
            cnt_d = cnt_q - CYCW'(1);
          end
          if (cnt_q <= CYCW'(1)) begin
            st_d = S_DONE;
          end else if (early_stop_i) begin
            st_d = S_DONE;
            ea_d = 1'b1;
          end
        end
        S_DONE: begin
          if (done_ready) begin
            st_d = S_IDLE;
          end
        end
        default: st_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q      <= S_IDLE;
      cnt_q     <= '0;
      ld_q      <= '0;
      fi_q      <= 1'b0;
      sqrt_q    <= 1'b0;
      special_q <= 1'b0;
      early_q   <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      ld_q      <= ld_d;
      fi_q      <= fi_d;
      sqrt_q    <= sq_d;
      special_q <= sp_d;
      early_q   <= ea_d;
    end
  end

endmodule

// File: tb/tb_fdivsqrt_r4ctrl.sv
// tb_fdivsqrt_r4ctrl: scoreboard bench for the div/sqrt iteration sequencer.
// Expected results are queued at accept and popped when the result handshake completes.
module tb_fdivsqrt_r4ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req_valid = 1'b0;
  logic       sqrt_i = 1'b0;
  logic [5:0] cycles_i = '0;
  logic       special_i = 1'b0;
  logic       early_stop_i = 1'b0;
  logic       flush = 1'b0;
  logic       done_ready = 1'b0;
  logic       req_ready, init, iter_en, first_iter;
  logic       sqrt_q, busy, done_valid, special_q, early_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         done_cyc;
    int         iters;
    int         fi_cnt;
    int         fi_cyc;
    int         ready_cyc;
    int         dv_cyc;
    logic [2:0] flags;
  } exp_t;

  typedef struct {
    int         done_cyc;
    int         iters;
    int         fi_cnt;
    int         fi_cyc;
    int         ready_cyc;
    int         dv_cyc;
    logic [2:0] flags;
    bit         flags_moved;
    bit         init0;
    bit         init_late;
    bit         timeout;
  } obs_t;

  exp_t sbq[$];

  fdivsqrt_r4ctrl #(.CYCW(6)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .sqrt_i(sqrt_i), .cycles_i(cycles_i),
    .special_i(special_i), .early_stop_i(early_stop_i),
    .flush(flush), .init(init), .iter_en(iter_en),
    .first_iter(first_iter), .sqrt_q(sqrt_q), .busy(busy),
    .done_valid(done_valid), .done_ready(done_ready),
    .special_q(special_q), .early_q(early_q)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic sq, input logic sp,
                                 input logic [5:0] cyc,
                                 input int early_at, input int hold);
    exp_t e;
    bit norm, es;
    norm = !sp && (cyc != 0);
    es   = norm && (early_at > 0) && (early_at < int'(cyc));
    e.done_cyc  = !norm ? 1 : (es ? early_at + 1 : int'(cyc) + 1);
    e.iters     = e.done_cyc - 1;
    e.fi_cnt    = norm ? 1 : 0;
    e.fi_cyc    = norm ? 1 : -1;
    e.dv_cyc    = hold + 1;
    e.ready_cyc = e.done_cyc + hold + 1;
    e.flags     = {sq, sp, es};
    return e;
  endfunction

  // Drives one operation and records what the DUT did; no judging here.
  task automatic run_op(input logic sq, input logic sp,
                        input logic [5:0] cyc, input int early_at,
                        input int hold, output obs_t o);
    int dvn;
    dvn = 0;
    o.done_cyc = -1; o.iters = 0; o.fi_cnt = 0; o.fi_cyc = -1;
    o.ready_cyc = -1; o.dv_cyc = 0; o.flags = '0;
    o.flags_moved = 0; o.init0 = 0; o.init_late = 0; o.timeout = 0;
    req_valid = 1; sqrt_i = sq; special_i = sp; cycles_i = cyc;
    done_ready = 0;
    @(negedge clk);
    o.init0 = init;
    @(posedge clk); #1;
    req_valid = 0; sqrt_i = 0; special_i = 0; cycles_i = 0;
    for (int c = 1; c <= 200; c++) begin
      early_stop_i = (c == early_at);
      done_ready   = done_valid && (dvn >= hold);
      req_valid    = done_valid;
      cycles_i     = done_valid ? 6'd3 : 6'd0;
      @(negedge clk);
      if (iter_en) o.iters++;
      if (first_iter) begin o.fi_cnt++; o.fi_cyc = c; end
      if (init) o.init_late = 1;
      if (done_valid) begin
        if (dvn == 0) begin
          o.done_cyc = c;
          o.flags = {sqrt_q, special_q, early_q};
        end else if ({sqrt_q, special_q, early_q} !== o.flags) begin
          o.flags_moved = 1;
        end
        dvn++;
      end
      if (req_ready) o.ready_cyc = c;
      @(posedge clk); #1;
      if (o.ready_cyc > 0) break;
      if (c == 200) o.timeout = 1;
    end
    early_stop_i = 0; done_ready = 0; req_valid = 0; cycles_i = 0;
    o.dv_cyc = dvn;
  endtask

  task automatic test_reset;
    resetn = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({req_ready, busy, done_valid, iter_en, init, first_iter,
         sqrt_q, special_q, early_q} !== 9'b100000000) begin
      errors++;
      $display("FAIL reset_state: got %b want 100000000",
        {req_ready, busy, done_valid, iter_en, init, first_iter,
         sqrt_q, special_q, early_q});
    end
    @(posedge clk); #1;
    resetn = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_divide;
    obs_t o; exp_t e;
    sbq.push_back(model(0, 0, 6'd5, 0, 0));
    run_op(0, 0, 6'd5, 0, 0, o);
    e = sbq.pop_front();
    checks++;
    if (o.init0 !== 1'b1 || o.init_late !== 1'b0) begin
      errors++;
      $display("FAIL divide_init: got init0=%0b late=%0b want 1 0", o.init0, o.init_late);
    end
    checks++;
    if (o.timeout || o.done_cyc !== e.done_cyc || o.iters !== e.iters || o.ready_cyc !== e.ready_cyc) begin
      errors++;
      $display("FAIL divide_timing: got done=%0d iters=%0d ready=%0d want %0d %0d %0d",
        o.done_cyc, o.iters, o.ready_cyc, e.done_cyc, e.iters, e.ready_cyc);
    end
    checks++;
    if (o.fi_cnt !== e.fi_cnt || o.fi_cyc !== e.fi_cyc) begin
      errors++;
      $display("FAIL divide_first_iter: got cnt=%0d cyc=%0d want %0d %0d",
        o.fi_cnt, o.fi_cyc, e.fi_cnt, e.fi_cyc);
    end
    checks++;
    if (o.flags !== e.flags) begin
      errors++;
      $display("FAIL divide_flags: got %b want %b", o.flags, e.flags);
    end
  endtask

  task automatic test_special;
    obs_t o; exp_t e;
    logic [5:0] cyc;
    logic sp;
    for (int k = 0; k < 2; k++) begin
      cyc = (k == 0) ? 6'd7 : 6'd0;
      sp  = (k == 0);
      sbq.push_back(model(1, sp, cyc, 0, 0));
      run_op(1, sp, cyc, 0, 0, o);
      e = sbq.pop_front();
      checks++;
      if (o.timeout || o.done_cyc !== e.done_cyc || o.iters !== e.iters || o.fi_cnt !== e.fi_cnt) begin
        errors++;
        $display("FAIL special_timing[%0d]: got done=%0d iters=%0d fi=%0d want %0d %0d %0d",
          k, o.done_cyc, o.iters, o.fi_cnt, e.done_cyc, e.iters, e.fi_cnt);
      end
      checks++;
      if (o.flags !== e.flags) begin
        errors++;
        $display("FAIL special_flags[%0d]: got %b want %b", k, o.flags, e.flags);
      end
    end
  endtask

  task automatic test_early;
    obs_t o; exp_t e;
    int at;
    for (int k = 0; k < 2; k++) begin
      at = (k == 0) ? 3 : 10;
      sbq.push_back(model(0, 0, 6'd10, at, 0));
      run_op(0, 0, 6'd10, at, 0, o);
      e = sbq.pop_front();
      checks++;
      if (o.timeout || o.done_cyc !== e.done_cyc || o.iters !== e.iters) begin
        errors++;
        $display("FAIL early_timing[%0d]: got done=%0d iters=%0d want %0d %0d",
          k, o.done_cyc, o.iters, e.done_cyc, e.iters);
      end
      checks++;
      if (o.flags !== e.flags) begin
        errors++;
        $display("FAIL early_flags[%0d]: got %b want %b", k, o.flags, e.flags);
      end
    end
  endtask

  task automatic test_backpressure;
    obs_t o; exp_t e;
    sbq.push_back(model(1, 0, 6'd4, 2, 4));
    run_op(1, 0, 6'd4, 2, 4, o);
    e = sbq.pop_front();
    checks++;
    if (o.timeout || o.done_cyc !== e.done_cyc || o.dv_cyc !== e.dv_cyc || o.ready_cyc !== e.ready_cyc) begin
      errors++;
      $display("FAIL hold_timing: got done=%0d dv=%0d ready=%0d want %0d %0d %0d",
        o.done_cyc, o.dv_cyc, o.ready_cyc, e.done_cyc, e.dv_cyc, e.ready_cyc);
    end
    checks++;
    if (o.flags !== e.flags || o.flags_moved) begin
      errors++;
      $display("FAIL hold_flags: got %b moved=%0b want %b moved=0", o.flags, o.flags_moved, e.flags);
    end
    checks++;
    if (o.init_late !== 1'b0) begin
      errors++;
      $display("FAIL hold_ignore_req: got init=%0b want 0", o.init_late);
    end
  endtask

  task automatic test_flush;
    bit seen;
    req_valid = 1; sqrt_i = 0; special_i = 0; cycles_i = 6'd6; done_ready = 1;
    @(posedge clk); #1;
    req_valid = 0; cycles_i = 0;
    @(posedge clk); #1;
    flush = 1;
    @(negedge clk);
    checks++;
    if (iter_en !== 1'b0 || done_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: got iter_en=%0b dv=%0b want 0 0", iter_en, done_valid);
    end
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy_idle: got busy=%0b rdy=%0b want 0 1", busy, req_ready);
    end
    @(posedge clk); #1;
    seen = 0;
    repeat (8) begin
      @(negedge clk); seen |= done_valid | iter_en;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_busy_quiet: got activity=1 want 0");
    end
    req_valid = 1; special_i = 1; done_ready = 0;
    @(posedge clk); #1;
    req_valid = 0; special_i = 0;
    flush = 1;
    @(negedge clk);
    checks++;
    if (done_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_done: got dv=%0b busy=%0b want 0 1", done_valid, busy);
    end
    @(posedge clk); #1;
    flush = 0;
    seen = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_done_idle: got busy=%0b want 0", busy);
    end
    @(posedge clk); #1;
    repeat (4) begin
      @(negedge clk); seen |= done_valid;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_done_quiet: got dv=1 want 0");
    end
    req_valid = 1; cycles_i = 6'd3; flush = 1;
    @(negedge clk);
    checks++;
    if (init !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_req: got init=%0b rdy=%0b want 0 0", init, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 0; cycles_i = 0; flush = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || iter_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_req_idle: got busy=%0b iter=%0b want 0 0", busy, iter_en);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    obs_t o; exp_t e;
    req_valid = 1; sqrt_i = 1; special_i = 0; cycles_i = 6'd8; done_ready = 1;
    @(posedge clk); #1;
    req_valid = 0; sqrt_i = 0; cycles_i = 0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1 || sqrt_q !== 1'b1 || iter_en !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got busy=%0b sqrt=%0b iter=%0b want 1 1 1", busy, sqrt_q, iter_en);
    end
    #2 resetn = 0;
    #1;
    checks++;
    if ({req_ready, busy, done_valid, iter_en, init, first_iter,
         sqrt_q, special_q, early_q} !== 9'b100000000) begin
      errors++;
      $display("FAIL areset_now: got %b want 100000000",
        {req_ready, busy, done_valid, iter_en, init, first_iter,
         sqrt_q, special_q, early_q});
    end
    repeat (2) @(posedge clk);
    #3 resetn = 1;
    @(posedge clk); #1;
    sbq.push_back(model(0, 0, 6'd2, 0, 0));
    run_op(0, 0, 6'd2, 0, 0, o);
    e = sbq.pop_front();
    checks++;
    if (o.timeout || o.done_cyc !== e.done_cyc || o.iters !== e.iters || o.flags !== e.flags) begin
      errors++;
      $display("FAIL areset_after: got done=%0d iters=%0d flags=%b want %0d %0d %b",
        o.done_cyc, o.iters, o.flags, e.done_cyc, e.iters, e.flags);
    end
  endtask

  task automatic test_back_to_back;
    obs_t o; exp_t e;
    logic sq, sp;
    logic [5:0] cyc;
    int at, hold;
    for (int k = 0; k < 8; k++) begin
      sq   = 1'($urandom_range(0, 1));
      sp   = ($urandom_range(0, 4) == 0);
      cyc  = 6'($urandom_range(0, 12));
      at   = int'($urandom_range(0, 14));
      hold = int'($urandom_range(0, 2));
      sbq.push_back(model(sq, sp, cyc, at, hold));
      run_op(sq, sp, cyc, at, hold, o);
      e = sbq.pop_front();
      checks++;
      if (o.timeout || o.done_cyc !== e.done_cyc || o.iters !== e.iters ||
          o.ready_cyc !== e.ready_cyc || o.fi_cnt !== e.fi_cnt) begin
        errors++;
        $display("FAIL b2b_timing[%0d]: got done=%0d it=%0d rdy=%0d fi=%0d want %0d %0d %0d %0d",
          k, o.done_cyc, o.iters, o.ready_cyc, o.fi_cnt,
          e.done_cyc, e.iters, e.ready_cyc, e.fi_cnt);
      end
      checks++;
      if (o.flags !== e.flags || o.flags_moved) begin
        errors++;
        $display("FAIL b2b_flags[%0d]: got %b moved=%0b want %b", k, o.flags, o.flags_moved, e.flags);
      end
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_special();
    test_early();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
